// File: rtl/data_bus_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_bus_ctrl_if : memory-stage data bus (core -> data_bus_ctrl)     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface data_bus_ctrl_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output memwrite,
        output addr,
        output writedata,
        input  readdata
    );

    modport slave (
        input  memwrite,
        input  addr,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/data_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_bus_ctrl : data RAM plus LED/switch/cycle/timer peripherals     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module data_bus_ctrl #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] IO_BASE   = 32'h1000_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    data_bus_ctrl_if.slave   bus,
    input  wire logic [15:0] switches,
    output logic      [15:0] led,
    output logic             timer_irq
);
    localparam int          c_aw        = $clog2(RAM_WORDS);
    localparam logic [31:0] c_ram_bytes = 32'(RAM_WORDS) << 2;

    localparam logic [2:0] c_off_led    = 3'd0;
    localparam logic [2:0] c_off_switch = 3'd1;
    localparam logic [2:0] c_off_cycle  = 3'd2;
    localparam logic [2:0] c_off_cmp    = 3'd3;
    localparam logic [2:0] c_off_ctrl   = 3'd4;
    localparam logic [2:0] c_off_status = 3'd5;
    localparam logic [2:0] c_off_tcnt   = 3'd6;

    logic [31:0]     r_mem [RAM_WORDS];
    logic [15:0]     r_led;
    logic [31:0]     r_cycle;
    logic [31:0]     r_cmp;
    logic            r_en;
    logic [31:0]     r_tcnt;
    logic            r_pending;

    logic            w_ram_sel;
    logic            w_io_sel;
    logic [c_aw-1:0] w_idx;
    logic [2:0]      w_off;
    logic            w_io_wr;
    logic            w_match;
    logic            w_unused;

    assign w_ram_sel = (bus.addr < c_ram_bytes);
    assign w_io_sel  = (bus.addr[31:5] == IO_BASE[31:5]);
    assign w_idx     = bus.addr[c_aw+1:2];
    assign w_off     = bus.addr[4:2];
    assign w_io_wr   = bus.memwrite && w_io_sel && !w_ram_sel;
    assign w_match   = r_en && (r_tcnt == r_cmp);
    // Byte lane bits carry no meaning on a word-only bus.
    assign w_unused  = ^bus.addr[1:0];

    assign led       = r_led;
    assign timer_irq = r_pending;

    always_ff @(posedge clk) begin
        if (bus.memwrite && w_ram_sel) begin
            r_mem[w_idx] <= bus.writedata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led     <= 16'h0;
            r_cycle   <= 32'h0;
            r_cmp     <= 32'hFFFF_FFFF;
            r_en      <= 1'b0;
            r_tcnt    <= 32'h0;
            r_pending <= 1'b0;
        end else begin
            if (w_io_wr && w_off == c_off_cycle) begin
                r_cycle <= bus.writedata;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end

            if (w_io_wr && w_off == c_off_led) begin
                r_led <= bus.writedata[15:0];
            end

            if (w_io_wr && w_off == c_off_cmp) begin
                r_cmp <= bus.writedata;
            end

            if (w_io_wr && w_off == c_off_ctrl) begin
                r_en <= bus.writedata[0];
            end

            // Disabling via CTRL restarts the count from zero.
            if (w_io_wr && w_off == c_off_ctrl && !bus.writedata[0]) begin
                r_tcnt <= 32'h0;
            end else if (r_en) begin
                r_tcnt <= w_match ? 32'h0 : r_tcnt + 32'd1;
            end

            // A match in the same cycle as a W1C clear keeps pending set.
            if (w_match) begin
                r_pending <= 1'b1;
            end else if (w_io_wr && w_off == c_off_status && bus.writedata[0]) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.readdata = 32'h0;
        if (w_ram_sel) begin
            bus.readdata = r_mem[w_idx];
        end else if (w_io_sel) begin
            case (w_off)
                c_off_led:    bus.readdata = {16'h0, r_led};
                c_off_switch: bus.readdata = {16'h0, switches};
                c_off_cycle:  bus.readdata = r_cycle;
                c_off_cmp:    bus.readdata = r_cmp;
                c_off_ctrl:   bus.readdata = {31'h0, r_en};
                c_off_status: bus.readdata = {31'h0, r_pending};
                c_off_tcnt:   bus.readdata = r_tcnt;
                default:      bus.readdata = 32'h0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_bus_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_bus_ctrl : directed + random bench against a register model  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_data_bus_ctrl;
    localparam int          RAM_WORDS = 1024;
    localparam logic [31:0] IO_BASE   = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] switches;
    logic [15:0] led;
    logic        timer_irq;

    data_bus_ctrl_if bus ();

    data_bus_ctrl #(.RAM_WORDS(RAM_WORDS), .IO_BASE(IO_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .switches  (switches),
        .led       (led),
        .timer_irq (timer_irq)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural register model
    logic [31:0] m_mem [int];
    logic [15:0] m_led;
    logic [31:0] m_cycle, m_cmp, m_tcnt;
    logic        m_en, m_pend;

    logic [31:0] rd_v;
    logic        s_irq;
    logic [15:0] s_led;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_led = 16'h0; m_cycle = 32'h0; m_cmp = 32'hFFFF_FFFF;
        m_en = 1'b0; m_tcnt = 32'h0; m_pend = 1'b0;
    endtask

    function automatic bit is_io(input logic [31:0] a);
        logic [31:0] base;
        base = IO_BASE;
        return (a >> 5) == (base >> 5);
    endfunction

    task automatic model_read(input logic [31:0] a, output bit known, output logic [31:0] v);
        int idx;
        known = 1'b1;
        v = 32'h0;
        if (a < RAM_WORDS * 4) begin
            idx = int'((a >> 2) % RAM_WORDS);
            if (m_mem.exists(idx)) v = m_mem[idx];
            else known = 1'b0;
        end else if (is_io(a)) begin
            case ((a >> 2) % 8)
                0: v = {16'h0, m_led};
                1: v = {16'h0, switches};
                2: v = m_cycle;
                3: v = m_cmp;
                4: v = {31'h0, m_en};
                5: v = {31'h0, m_pend};
                6: v = m_tcnt;
                default: v = 32'h0;
            endcase
        end
    endtask

    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] n_cycle, n_tcnt;
        logic        n_pend, hit;
        hit     = m_en && (m_tcnt == m_cmp);
        n_cycle = m_cycle + 1;
        n_tcnt  = !m_en ? m_tcnt : (hit ? 32'h0 : m_tcnt + 1);
        n_pend  = m_pend;
        if (we && a < RAM_WORDS * 4) begin
            m_mem[int'((a >> 2) % RAM_WORDS)] = wd;
        end else if (we && is_io(a)) begin
            case ((a >> 2) % 8)
                0: m_led = wd[15:0];
                2: n_cycle = wd;
                3: m_cmp = wd;
                4: begin m_en = wd[0]; if (!wd[0]) n_tcnt = 32'h0; end
                5: if (wd[0]) n_pend = 1'b0;
                default: ;
            endcase
        end
        if (hit) n_pend = 1'b1;
        m_cycle = n_cycle;
        m_tcnt  = n_tcnt;
        m_pend  = n_pend;
    endtask

    task automatic bus_cycle(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd);
        logic [31:0] exp;
        bit          known;
        @(negedge clk);
        bus.memwrite  = we;
        bus.addr      = a;
        bus.writedata = wd;
        #1;
        model_read(a, known, exp);
        rd    = bus.readdata;
        s_irq = timer_irq;
        s_led = led;
        if (known) check_eq("readdata", bus.readdata, exp);
        check_eq("led", {16'h0, led}, {16'h0, m_led});
        check_eq("timer_irq", {31'h0, timer_irq}, {31'h0, m_pend});
        @(posedge clk);
        model_step(we, a, wd);
    endtask

    task automatic rd(input logic [31:0] a);
        bus_cycle(1'b0, a, $urandom, rd_v);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_cycle(1'b1, a, d, rd_v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.memwrite  = 1'b0;
        bus.writedata = 32'h0;
        bus.addr      = IO_BASE | 32'h08;
        #1 rst = 1'b1;
        #1 check_eq("rst_cycle", bus.readdata, 32'h0);
        check_eq("rst_led", {16'h0, led}, 32'h0);
        check_eq("rst_irq", {31'h0, timer_irq}, 32'h0);
        bus.addr = IO_BASE | 32'h18;
        #1 check_eq("rst_tcnt", bus.readdata, 32'h0);
        bus.addr = IO_BASE | 32'h0C;
        #1 check_eq("rst_cmp", bus.readdata, 32'hFFFF_FFFF);
        bus.addr = IO_BASE | 32'h10;
        #1 check_eq("rst_ctrl", bus.readdata, 32'h0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        model_step(1'b0, bus.addr, 32'h0);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] unm [4];
        unm[0] = 32'h2000_0000; unm[1] = RAM_WORDS * 4;
        unm[2] = IO_BASE | 32'h20; unm[3] = 32'hFFFF_FFFC;
        case ($urandom % 10)
            0, 1, 2, 3: return (($urandom % 16) << 2) | ($urandom % 4);
            4, 5, 6, 7: return IO_BASE | (($urandom % 8) << 2) | ($urandom % 4);
            8:          return unm[$urandom % 4];
            default:    return $urandom % (RAM_WORDS * 4);
        endcase
    endfunction

    initial begin
        logic [31:0] tseq [5];
        logic [31:0] a, d;
        tseq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        switches      = 16'h0;
        bus.memwrite  = 1'b0;
        bus.addr      = 32'h0;
        bus.writedata = 32'h0;
        model_reset();
        do_reset();
        rd(IO_BASE | 32'h08);
        check_eq("cycle_after_rst", rd_v, 32'd1);

        // RAM write/read and read-during-write
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h13);
        check_eq("ram_rd", rd_v, 32'hDEAD_BEEF);
        wr(32'h14, 32'h1111_1111);
        bus_cycle(1'b1, 32'h14, 32'h2222_2222, rd_v);
        check_eq("ram_rdw_old", rd_v, 32'h1111_1111);
        rd(32'h14);
        check_eq("ram_rdw_new", rd_v, 32'h2222_2222);

        // LED / switches
        wr(IO_BASE, 32'h1234_A5A5);
        rd(IO_BASE);
        check_eq("led_rd", rd_v, 32'h0000_A5A5);
        check_eq("led_pin", {16'h0, s_led}, 32'h0000_A5A5);
        switches = 16'h00FF;
        rd(IO_BASE | 32'h04);
        check_eq("switch_rd", rd_v, 32'h0000_00FF);
        wr(IO_BASE | 32'h04, 32'hFFFF_0000);
        rd(IO_BASE | 32'h04);
        check_eq("switch_ro", rd_v, 32'h0000_00FF);

        // Cycle counter wrap
        wr(IO_BASE | 32'h08, 32'hFFFF_FFFE);
        rd(IO_BASE | 32'h08); check_eq("cyc_fe", rd_v, 32'hFFFF_FFFE);
        rd(IO_BASE | 32'h08); check_eq("cyc_ff", rd_v, 32'hFFFF_FFFF);
        rd(IO_BASE | 32'h08); check_eq("cyc_00", rd_v, 32'h0);

        // Timer: CMP=3, count 0..3 with sticky pending
        wr(IO_BASE | 32'h0C, 32'd3);
        wr(IO_BASE | 32'h10, 32'd1);
        for (int i = 0; i < 5; i++) begin
            rd(IO_BASE | 32'h18);
            check_eq("tcnt_seq", rd_v, tseq[i]);
            check_eq("irq_seq", {31'h0, s_irq}, (i == 4) ? 32'd1 : 32'd0);
        end
        wr(IO_BASE | 32'h14, 32'd1);             // clear, tcnt=1
        rd(IO_BASE | 32'h14); check_eq("pend_clr", rd_v, 32'd0);
        check_eq("irq_clr", {31'h0, s_irq}, 32'd0);
        rd(IO_BASE | 32'h14);                    // tcnt=3, matches
        rd(IO_BASE | 32'h14); check_eq("pend_set", rd_v, 32'd1);
        rd(IO_BASE | 32'h18);
        rd(IO_BASE | 32'h18);
        wr(IO_BASE | 32'h14, 32'd1);             // clear coincides with match
        rd(IO_BASE | 32'h14); check_eq("pend_set_wins", rd_v, 32'd1);
        check_eq("irq_set_wins", {31'h0, s_irq}, 32'd1);
        wr(IO_BASE | 32'h10, 32'd0);
        rd(IO_BASE | 32'h18); check_eq("tcnt_disable", rd_v, 32'd0);
        wr(IO_BASE | 32'h14, 32'd1);

        // Unmapped / reserved
        a = RAM_WORDS * 4;
        wr(IO_BASE | 32'h1C, 32'hFFFF_FFFF);
        wr(32'h2000_0000, 32'hFFFF_FFFF);
        wr(a, 32'hFFFF_FFFF);
        rd(IO_BASE | 32'h1C); check_eq("rsvd_rd", rd_v, 32'h0);
        rd(32'h2000_0000);    check_eq("unm_rd", rd_v, 32'h0);
        rd(a);                check_eq("ram_end_rd", rd_v, 32'h0);
        rd(IO_BASE | 32'h0C); check_eq("cmp_kept", rd_v, 32'd3);

        // Async reset with timer running and LEDs on
        wr(IO_BASE, 32'h0000_FFFF);
        wr(IO_BASE | 32'h0C, 32'd2);
        wr(IO_BASE | 32'h10, 32'd1);
        repeat (4) rd(IO_BASE | 32'h18);
        do_reset();
        rd(IO_BASE | 32'h08); check_eq("cycle_after_rst2", rd_v, 32'd1);
        rd(32'h10); check_eq("ram_survives_rst", rd_v, 32'hDEAD_BEEF);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            switches = 16'($urandom);
            a = pick_addr();
            d = $urandom;
            if (is_io(a) && ((a >> 2) % 8) == 3) d = $urandom % 6;
            if (is_io(a) && ((a >> 2) % 8) == 4) d[0] = ($urandom % 4) != 0;
            bus_cycle(1'($urandom % 2), a, d, rd_v);
            if (i % 1000 == 999) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
